// File: rtl/adc_serie_lector_pkg.sv
// Shared definitions for the serial ADC front-end and its downstream stages.
//   - estado_e    : frame sequencer state encoding
//   - AdcWidth    : ADC result width, also used by the 8-to-4 reduction stage
//   - Def*        : default timing parameters
//   - cnt_width() : counter width for a counter that wraps at 'modulus'
package adc_serie_lector_pkg;

  localparam int unsigned AdcWidth     = 8;
  localparam int unsigned DefClkDiv    = 50;
  localparam int unsigned DefStartBits = 1;
  localparam int unsigned DefGap       = 100;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StDone,
    StGap
  } estado_e;

  // Bits needed to count 0 .. modulus-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/adc_serie_lector_sincronizador.sv
// Generic 2-flop synchronizer for signals crossing into the 'reloj' domain.
// Ports:
//   reloj : destination clock
//   reset : synchronous, active-high; both stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two 'reloj' cycles of latency
module sincronizador #(
  parameter int unsigned W = 1
) (
  input  logic         reloj,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge reloj) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_serie_lector.sv
// Serial ADC front-end for an ADC0831-style converter (CS, SCLK, MSB-first DOUT).
// Runs one conversion per frame and presents the result as a held parallel word.
// Ports:
//   reloj    : system clock
//   reset    : synchronous, active-high
//   en       : level; while high, frames run back-to-back
//   adc_dout : ADC serial data, asynchronous to reloj
//   adc_cs_n : ADC chip select, active low
//   adc_sclk : ADC serial clock, period 2*CLK_DIV
//   Ocho     : last completed conversion, held between frames
//   valido   : one-cycle pulse when Ocho updates
//   ocupado  : high while a frame is in progress
module adc_serie_lector
  import adc_serie_lector_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DefClkDiv,
  parameter int unsigned START_BITS = DefStartBits,
  parameter int unsigned DATA_W     = AdcWidth,
  parameter int unsigned GAP        = DefGap
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              en,
  input  logic              adc_dout,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] Ocho,
  output logic              valido,
  output logic              ocupado
);

  localparam int unsigned N  = START_BITS + DATA_W;
  localparam int unsigned HW = cnt_width(CLK_DIV);
  localparam int unsigned PW = cnt_width(N + 1);
  localparam int unsigned GW = cnt_width(GAP + 1);

  localparam logic [HW-1:0] HLast = HW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PLast = PW'(N - 1);
  localparam logic [GW-1:0] GLast = GW'(GAP - 1);

  estado_e           state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              phase_q, phase_d;  // 1 while SCLK is in its high half
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] ocho_q, ocho_d;
  logic              cs_n_q, sclk_q, valido_q, ocupado_q;
  logic              dout_s;

  sincronizador #(
    .W(1)
  ) u_sincronizador (
    .reloj(reloj),
    .reset(reset),
    .d    (adc_dout),
    .q    (dout_s)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    phase_d = phase_q;
    shift_d = shift_q;
    ocho_d  = ocho_q;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StSetup;
          hcnt_d  = '0;
        end
      end

      StSetup: begin
        if (hcnt_q == HLast) begin
          hcnt_d  = '0;
          pcnt_d  = '0;
          phase_d = 1'b1;
          state_d = StShift;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      StShift: begin
        if (hcnt_q != HLast) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = '0;
          if (phase_q) begin
            // End of the high half: data has been stable long enough to
            // pass through the synchronizer. Leading dummy samples are dropped.
            phase_d = 1'b0;
            if (32'(pcnt_q) + 32'd1 > START_BITS) begin
              shift_d = {shift_q[DATA_W-2:0], dout_s};
            end
          end else if (pcnt_q == PLast) begin
            // Load on entry to DONE so Ocho and valido change on the same edge.
            pcnt_d  = '0;
            ocho_d  = shift_q;
            state_d = StDone;
          end else begin
            phase_d = 1'b1;
            pcnt_d  = pcnt_q + 1'b1;
          end
        end
      end

      StDone: begin
        gcnt_d = '0;
        if (GAP == 0) begin
          state_d = en ? StSetup : StIdle;
        end else begin
          state_d = StGap;
        end
      end

      StGap: begin
        if (gcnt_q == GLast) begin
          gcnt_d  = '0;
          hcnt_d  = '0;
          state_d = en ? StSetup : StIdle;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on the
  // same edge as the state they describe.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      pcnt_q    <= '0;
      gcnt_q    <= '0;
      phase_q   <= 1'b0;
      shift_q   <= '0;
      ocho_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      pcnt_q    <= pcnt_d;
      gcnt_q    <= gcnt_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      ocho_q    <= ocho_d;
      cs_n_q    <= !((state_d == StSetup) || (state_d == StShift));
      sclk_q    <= (state_d == StShift) && phase_d;
      valido_q  <= (state_d == StDone);
      ocupado_q <= (state_d != StIdle);
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign Ocho     = ocho_q;
  assign valido   = valido_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_adc_serie_lector.sv
// Bench for adc_serie_lector: one default-parameter instance for frame timing,
// reset and enable behaviour, and one fast instance (CLK_DIV=4, no dummy bit)
// fed random codes with random data skew.
module tb_adc_serie_lector;

  localparam int unsigned H0   = 50;
  localparam int unsigned SB0  = 1;
  localparam int unsigned GAP0 = 100;
  localparam int unsigned N0   = SB0 + 8;
  localparam int unsigned LAT0 = H0 + 2 * H0 * N0;
  localparam int unsigned H1   = 4;
  localparam int unsigned GAP1 = 1;
  localparam int unsigned NF   = 400;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] en = 2'b00;
  logic [1:0] dout = 2'b00;
  logic [1:0] cs_n, sclk, valido, ocupado;
  logic [7:0] ocho0, ocho1;

  always #5 clk = ~clk;

  adc_serie_lector dut0 (
    .reloj   (clk),
    .reset   (rst[0]),
    .en      (en[0]),
    .adc_dout(dout[0]),
    .adc_cs_n(cs_n[0]),
    .adc_sclk(sclk[0]),
    .Ocho    (ocho0),
    .valido  (valido[0]),
    .ocupado (ocupado[0])
  );

  adc_serie_lector #(
    .CLK_DIV   (H1),
    .START_BITS(0),
    .DATA_W    (8),
    .GAP       (GAP1)
  ) dut1 (
    .reloj   (clk),
    .reset   (rst[1]),
    .en      (en[1]),
    .adc_dout(dout[1]),
    .adc_cs_n(cs_n[1]),
    .adc_sclk(sclk[1]),
    .Ocho    (ocho1),
    .valido  (valido[1]),
    .ocupado (ocupado[1])
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ADC behavioural model ----------------
  // Each frame: optional dummy bits then the code MSB-first; the next bit
  // appears after every SCLK falling edge.
  logic [7:0] codes0[$];
  logic [7:0] codes1[$];
  logic [7:0] cur[2];
  int         idx[2];
  bit         pend[2];
  bit         dummy[2];
  logic [1:0] m_csp = 2'b11;
  logic [1:0] m_sclkp = 2'b00;

  function automatic logic bitv(input int k);
    int sb, j;
    sb = (k == 0) ? int'(SB0) : 0;
    if (idx[k] < sb) return dummy[k];
    j = idx[k] - sb;
    if (j < 8) return cur[k][7-j];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        dout[k] = bitv(k);
        pend[k] = 1'b0;
      end
      if (m_csp[k] && !cs_n[k]) begin
        if (k == 0) cur[0] = (codes0.size() > 0) ? codes0.pop_front() : 8'($urandom);
        else        cur[1] = (codes1.size() > 0) ? codes1.pop_front() : 8'($urandom);
        idx[k]   = 0;
        dummy[k] = 1'($urandom);
        pend[k]  = 1'b0;
        dout[k]  = bitv(k);
      end else if (!cs_n[k] && m_sclkp[k] && !sclk[k]) begin
        idx[k]++;
        if (k == 1 && $urandom_range(1, 0) == 1) pend[k] = 1'b1;
        else dout[k] = bitv(k);
      end
      m_csp[k]   = cs_n[k];
      m_sclkp[k] = sclk[k];
    end
  end

  // ---------------- Output monitor ----------------
  typedef struct {
    logic [7:0] ocho;
    int         lat;
    int         rises;
    int         first;
    int         pviol;
  } frame_t;

  frame_t     fq0[$];
  logic [7:0] oq1[$];
  int         hiq0[$];
  int cyc = 0, t_fall0 = 0, t_rise0 = 0, t_lastr0 = 0;
  int rises0 = 0, first0 = -1, pviol0 = 0;
  int falls0 = 0, falls1 = 0, vcnt0 = 0, consec = 0, chg = 0;
  bit seen_hi0 = 1'b0;
  logic [1:0] p_cs = 2'b11, p_sclk = 2'b00, p_val = 2'b00;
  logic [7:0] p_o0 = 8'h00, p_o1 = 8'h00;

  always @(posedge clk) begin
    frame_t fr;
    #1;
    cyc++;
    if (p_cs[0] && !cs_n[0]) begin
      falls0++;
      if (seen_hi0) hiq0.push_back(cyc - t_rise0);
      t_fall0 = cyc;
      rises0  = 0;
      pviol0  = 0;
      first0  = -1;
    end
    if (!p_cs[0] && cs_n[0]) begin
      t_rise0  = cyc;
      seen_hi0 = 1'b1;
    end
    if (!p_sclk[0] && sclk[0]) begin
      if (rises0 == 0) first0 = cyc - t_fall0;
      else if (cyc - t_lastr0 != int'(2 * H0)) pviol0++;
      t_lastr0 = cyc;
      rises0++;
    end
    if (p_sclk[0] && !sclk[0] && (cyc - t_lastr0 != int'(H0))) pviol0++;
    if (valido[0]) begin
      vcnt0++;
      fr.ocho  = ocho0;
      fr.lat   = cyc - t_fall0;
      fr.rises = rises0;
      fr.first = first0;
      fr.pviol = pviol0;
      fq0.push_back(fr);
    end
    if (p_cs[1] && !cs_n[1]) falls1++;
    if (valido[1]) oq1.push_back(ocho1);
    for (int k = 0; k < 2; k++) if (p_val[k] && valido[k]) consec++;
    if (!valido[0] && !rst[0] && ocho0 !== p_o0) chg++;
    if (!valido[1] && !rst[1] && ocho1 !== p_o1) chg++;
    p_cs   = cs_n;
    p_sclk = sclk;
    p_val  = valido;
    p_o0   = ocho0;
    p_o1   = ocho1;
  end

  // ---------------- Helpers ----------------
  task automatic wait_frames0(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (fq0.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk({tag, "_tmo"}, fq0.size() >= n, 1);
  endtask

  task automatic wait_falls0(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (falls0 < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk({tag, "_tmo"}, falls0 >= n, 1);
  endtask

  task automatic check_frame0(input string tag, input logic [7:0] code);
    frame_t f;
    f.ocho = 8'hxx; f.lat = -1; f.rises = -1; f.first = -1; f.pviol = -1;
    if (fq0.size() > 0) f = fq0.pop_front();
    chk({tag, "_ocho"}, f.ocho, code);
    chk({tag, "_lat"}, f.lat, LAT0);
    chk({tag, "_rises"}, f.rises, N0);
    chk({tag, "_first"}, f.first, H0);
    chk({tag, "_period"}, f.pviol, 0);
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    int         fb, vb, b;
    logic [7:0] c;
    logic [7:0] exp1[$];

    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n[0], 1);
    chk("rst_sclk", sclk[0], 0);
    chk("rst_ocho", ocho0, 0);
    chk("rst_valido", valido[0], 0);
    chk("rst_ocupado", ocupado[0], 0);
    chk("rst_cs_n1", cs_n[1], 1);
    rst = 2'b00;
    repeat (5) @(negedge clk);

    // Single frame from a one-cycle enable pulse.
    codes0.push_back(8'hA5);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_frames0("a5", 1, 3000);
    check_frame0("a5", 8'hA5);
    repeat (GAP0 + 300) @(negedge clk);
    chk("a5_cs_idle", cs_n[0], 1);
    chk("a5_ocupado", ocupado[0], 0);
    chk("a5_falls", falls0, 1);
    chk("a5_valids", vcnt0, 1);

    // Back-to-back frames with en held high.
    codes0.push_back(8'h00);
    codes0.push_back(8'hFF);
    en[0] = 1'b1;
    wait_frames0("f00", 1, 3000);
    check_frame0("f00", 8'h00);
    hiq0.delete();
    wait_falls0("f2", 3, 500);
    en[0] = 1'b0;
    wait_frames0("fff", 1, 3000);
    check_frame0("fff", 8'hFF);
    chk("gap_hi", (hiq0.size() > 0) ? hiq0[0] : -1, GAP0 + 1);
    repeat (GAP0 + 300) @(negedge clk);

    // Reset in the middle of a frame, after the 4th data bit.
    codes0.push_back(8'h3C);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_falls0("r3c", 4, 100);
    repeat (H0 + 2 * H0 * (SB0 + 4) - 20) @(negedge clk);
    chk("r3c_busy", ocupado[0], 1);
    vb = vcnt0;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("r3c_cs_n", cs_n[0], 1);
    chk("r3c_sclk", sclk[0], 0);
    chk("r3c_ocho", ocho0, 0);
    chk("r3c_valido", valido[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (1100) @(negedge clk);
    chk("r3c_novalid", vcnt0, vb);
    chk("r3c_ocho_held", ocho0, 0);
    codes0.push_back(8'hC3);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_frames0("c3", 1, 3000);
    check_frame0("c3", 8'hC3);
    repeat (GAP0 + 50) @(negedge clk);

    // en dropped during SHIFT: frame completes, then idle.
    fb = falls0;
    codes0.push_back(8'h5A);
    en[0] = 1'b1;
    repeat (300) @(negedge clk);
    en[0] = 1'b0;
    wait_frames0("x5a", 1, 3000);
    check_frame0("x5a", 8'h5A);
    repeat (GAP0 + 300) @(negedge clk);
    chk("x5a_ocupado", ocupado[0], 0);
    chk("x5a_falls", falls0, fb + 1);
    chk("x5a_cs_n", cs_n[0], 1);

    // Random en/reset interleaving; invariants are tallied by the monitor.
    repeat (6000) begin
      @(negedge clk);
      en[0]  = ($urandom_range(3, 0) != 0);
      rst[0] = ($urandom_range(499, 0) == 0);
    end
    en[0]  = 1'b0;
    rst[0] = 1'b0;
    repeat (1200) @(negedge clk);
    chk("rnd_idle", ocupado[0], 0);

    // Fast instance: random codes with random data skew.
    for (int i = 0; i < int'(NF); i++) begin
      c = 8'($urandom);
      codes1.push_back(c);
      exp1.push_back(c);
    end
    en[1] = 1'b1;
    b = 100 * int'(NF);
    while (falls1 < int'(NF) && b > 0) begin
      @(negedge clk);
      b--;
    end
    en[1] = 1'b0;
    b = 500;
    while (oq1.size() < int'(NF) && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("fast_count", oq1.size(), NF);
    for (int i = 0; i < int'(NF); i++) begin
      chk($sformatf("fast_code%0d", i), (i < oq1.size()) ? oq1[i] : 8'hxx, exp1[i]);
    end

    chk("valido_consec", consec, 0);
    chk("ocho_chg_no_valido", chg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
